// File: rtl/interp_pkg.sv
// Shared definitions for the linear stream interpolator: default widths,
// derived-width helpers, FSM state encodings and the reset output code.
package interp_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_OUT_W    = 12;
    localparam int DEF_FRAC_W   = 16;
    localparam int DEF_MAX_LOG2 = 4;

    // Accumulator: sign guard + integer sample + fraction.
    function automatic int calc_acc_w(input int data_w, input int frac_w);
        return data_w + frac_w + 32'sd1;
    endfunction

    // Accumulator bits discarded below the output code.
    function automatic int calc_drop_w(input int data_w, input int frac_w, input int out_w);
        return frac_w + data_w - out_w;
    endfunction

    localparam int ACC_W  = calc_acc_w(DEF_DATA_W, DEF_FRAC_W);
    localparam int DROP_W = calc_drop_w(DEF_DATA_W, DEF_FRAC_W, DEF_OUT_W);

    typedef logic [1:0] state_t;
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    // Offset-binary code for a zero sample at the default output width.
    localparam logic [DEF_OUT_W-1:0] OUT_RESET_CODE = {1'b1, {(DEF_OUT_W-1){1'b0}}};

endpackage

// File: rtl/interp_linear_stream_if.sv
// Sample-in / point-out bundle of the interpolator. The slave modport is the
// interpolator itself; the master modport is the sample source and tick owner.
interface interp_linear_stream_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        ratio_sel;
    logic              tick;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              underrun;

    modport master (
        output in_valid, in_data, ratio_sel, tick,
        input  in_ready, out_valid, out_data, underrun
    );

    modport slave (
        input  in_valid, in_data, ratio_sel, tick,
        output in_ready, out_valid, out_data, underrun
    );
endinterface

// File: rtl/interp_delta_calc.sv
// Per-segment step size: (nxt - cur) scaled by 2^(FRAC_W - r), with the
// requested log2 ratio clamped to MAX_LOG2. Purely combinational.
module interp_delta_calc #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 16,
    parameter int MAX_LOG2 = 4
) (
    input  logic [DATA_W-1:0]      cur,
    input  logic [DATA_W-1:0]      nxt,
    input  logic [3:0]             ratio_sel,
    output logic [3:0]             r,
    output logic [DATA_W+FRAC_W:0] delta
);
    logic [DATA_W:0] diff_s;
    logic [7:0]      shamt_s;

    // Difference one bit wider than the samples so it never wraps, then scaled.
    always_comb begin
        diff_s = {nxt[DATA_W-1], nxt} - {cur[DATA_W-1], cur};
        if (ratio_sel > 4'(MAX_LOG2)) begin
            r = 4'(MAX_LOG2);
        end else begin
            r = ratio_sel;
        end
        shamt_s = 8'(FRAC_W) - {4'd0, r};
        delta   = {{FRAC_W{diff_s[DATA_W]}}, diff_s} << shamt_s;
    end
endmodule

// File: rtl/interp_linear_stream.sv
// Linear interpolator for the DDS output path: upsamples signed samples by
// 2^ratio_sel, one point per tick, as offset-binary DAC code. Each segment
// re-anchors the accumulator on its start sample, so no error accumulates.
// Optional build macro INTERP_ROUND_EN: round-to-nearest with positive
// saturation instead of plain truncation.
module interp_linear_stream
    import interp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
    input  logic                  Fg_CLK,
    input  logic                  RESET,
    interp_linear_stream_if.slave bus
);
    localparam int ACC_W  = calc_acc_w(DATA_W, FRAC_W);
    localparam int DROP_W = calc_drop_w(DATA_W, FRAC_W, OUT_W);
    localparam int PH_W   = MAX_LOG2 + 1;
    localparam logic [OUT_W-1:0] RST_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    state_t            state_r, state_nx;
    logic [DATA_W-1:0] cur_r, cur_nx, nxt_r, nxt_nx, stage_r, stage_nx;
    logic              stage_full_r, stage_full_nx;
    logic [ACC_W-1:0]  acc_r, acc_nx, delta_r, delta_nx;
    logic [PH_W-1:0]   phase_r, phase_nx, ph_last_s;
    logic [3:0]        r_r, r_nx;
    logic              out_valid_r, underrun_r;
    logic [OUT_W-1:0]  out_data_r, code_s;
    logic              in_ready_s, accept_s, last_s, emit_s, under_s;
    logic [DATA_W-1:0] dc_a_s, dc_b_s;
    logic [3:0]        dc_r_s;
    logic [ACC_W-1:0]  dc_delta_s;
`ifdef INTERP_ROUND_EN
    logic [ACC_W-1:0]  rnd_s;
`endif

    // Sample sign-extended and placed on the integer part of the accumulator.
    function automatic logic [ACC_W-1:0] anchor(input logic [DATA_W-1:0] s);
        return {s[DATA_W-1], s, {FRAC_W{1'b0}}};
    endfunction

    assign in_ready_s    = !RESET && !((state_r == ST_RUN) && stage_full_r);
    assign accept_s      = bus.in_valid && in_ready_s;
    assign ph_last_s     = (PH_W'(1'b1) << r_r) - PH_W'(1'b1);
    assign last_s        = (phase_r == ph_last_s);
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.underrun  = underrun_r;

    // Segment end points: ONE starts from cur, later segments from nxt; the
    // far end comes from the skid stage when it holds a sample.
    always_comb begin
        if (state_r == ST_ONE) begin
            dc_a_s = cur_r;
        end else begin
            dc_a_s = nxt_r;
        end
        if ((state_r == ST_RUN) && stage_full_r) begin
            dc_b_s = stage_r;
        end else begin
            dc_b_s = bus.in_data;
        end
    end

    interp_delta_calc #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .MAX_LOG2 (MAX_LOG2)
    ) u_delta (
        .cur       (dc_a_s),
        .nxt       (dc_b_s),
        .ratio_sel (bus.ratio_sel),
        .r         (dc_r_s),
        .delta     (dc_delta_s)
    );

    // Output code from the current accumulator: top OUT_W integer bits, MSB inverted.
    always_comb begin
`ifdef INTERP_ROUND_EN
        rnd_s = acc_r + (ACC_W'(1'b1) << (DROP_W - 1));
        if (!rnd_s[ACC_W-1] && rnd_s[ACC_W-2]) begin
            code_s = {1'b1, {(OUT_W-1){1'b1}}};
        end else begin
            code_s = {~rnd_s[ACC_W-2], rnd_s[ACC_W-3 -: OUT_W-1]};
        end
`else
        code_s = {~acc_r[ACC_W-2], acc_r[ACC_W-3 -: OUT_W-1]};
`endif
    end

    // Next-state logic: FSM, skid stage, accumulator and segment bookkeeping.
    always_comb begin
        state_nx      = state_r;
        cur_nx        = cur_r;
        nxt_nx        = nxt_r;
        stage_nx      = stage_r;
        stage_full_nx = stage_full_r;
        acc_nx        = acc_r;
        delta_nx      = delta_r;
        phase_nx      = phase_r;
        r_nx          = r_r;
        emit_s        = 1'b0;
        under_s       = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    cur_nx   = bus.in_data;
                    state_nx = ST_ONE;
                end else begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s) begin
                    nxt_nx   = bus.in_data;
                    acc_nx   = anchor(cur_r);
                    delta_nx = dc_delta_s;
                    phase_nx = {PH_W{1'b0}};
                    r_nx     = dc_r_s;
                    state_nx = ST_RUN;
                end else begin
                    state_nx = ST_ONE;
                end
            end
            ST_RUN: begin
                emit_s = bus.tick;
                if (bus.tick && last_s) begin
                    cur_nx   = nxt_r;
                    acc_nx   = anchor(nxt_r);
                    phase_nx = {PH_W{1'b0}};
                    if (stage_full_r || accept_s) begin
                        nxt_nx        = dc_b_s;
                        delta_nx      = dc_delta_s;
                        r_nx          = dc_r_s;
                        stage_full_nx = 1'b0;
                    end else begin
                        delta_nx = {ACC_W{1'b0}};
                        state_nx = ST_HOLD;
                    end
                end else begin
                    if (bus.tick) begin
                        acc_nx   = acc_r + delta_r;
                        phase_nx = phase_r + PH_W'(1'b1);
                    end else begin
                        acc_nx = acc_r;
                    end
                    if (accept_s) begin
                        stage_nx      = bus.in_data;
                        stage_full_nx = 1'b1;
                    end else begin
                        stage_full_nx = stage_full_r;
                    end
                end
            end
            ST_HOLD: begin
                emit_s  = bus.tick;
                under_s = bus.tick;
                if (accept_s) begin
                    cur_nx   = nxt_r;
                    nxt_nx   = bus.in_data;
                    r_nx     = dc_r_s;
                    phase_nx = {PH_W{1'b0}};
                    if (bus.tick && (dc_r_s == 4'd0)) begin
                        // The tick already produced the only point of this segment.
                        acc_nx   = anchor(bus.in_data);
                        delta_nx = {ACC_W{1'b0}};
                    end else if (bus.tick) begin
                        // The tick emitted point 0 of the new segment; continue at point 1.
                        acc_nx   = anchor(nxt_r) + dc_delta_s;
                        delta_nx = dc_delta_s;
                        phase_nx = PH_W'(1'b1);
                        state_nx = ST_RUN;
                    end else begin
                        acc_nx   = anchor(nxt_r);
                        delta_nx = dc_delta_s;
                        state_nx = ST_RUN;
                    end
                end else begin
                    state_nx = ST_HOLD;
                end
            end
            default: begin
                state_nx = ST_EMPTY;
            end
        endcase
    end

    // State and output registers with synchronous reset that drops every sample.
    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            state_r      <= ST_EMPTY;
            cur_r        <= {DATA_W{1'b0}};
            nxt_r        <= {DATA_W{1'b0}};
            stage_r      <= {DATA_W{1'b0}};
            stage_full_r <= 1'b0;
            acc_r        <= {ACC_W{1'b0}};
            delta_r      <= {ACC_W{1'b0}};
            phase_r      <= {PH_W{1'b0}};
            r_r          <= 4'd0;
            out_valid_r  <= 1'b0;
            underrun_r   <= 1'b0;
            out_data_r   <= RST_CODE;
        end else begin
            state_r      <= state_nx;
            cur_r        <= cur_nx;
            nxt_r        <= nxt_nx;
            stage_r      <= stage_nx;
            stage_full_r <= stage_full_nx;
            acc_r        <= acc_nx;
            delta_r      <= delta_nx;
            phase_r      <= phase_nx;
            r_r          <= r_nx;
            out_valid_r  <= emit_s;
            underrun_r   <= under_s;
            if (emit_s) begin
                out_data_r <= code_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end
endmodule

// File: tb/tb_interp_linear_stream.sv
// Directed bench for interp_linear_stream with hand-computed expected codes.
module tb_interp_linear_stream;
    import interp_pkg::*;

    logic Fg_CLK = 1'b0;
    logic RESET  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    interp_linear_stream_if #(.DATA_W(16), .OUT_W(12)) bus ();

    interp_linear_stream #(
        .DATA_W(16), .OUT_W(12), .FRAC_W(16), .MAX_LOG2(4)
    ) dut (
        .Fg_CLK (Fg_CLK),
        .RESET  (RESET),
        .bus    (bus)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    logic [11:0] exp_ramp  [4] = '{12'h800, 12'h840, 12'h880, 12'h8C0};
    logic [15:0] pt_stream [6] = '{16'h7FF0, 16'h8000, 16'h7FF0, 16'h8000, 16'h7FF0, 16'h8000};
    logic [11:0] exp_pt    [4] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
    logic [11:0] exp_rc    [7] = '{12'h800, 12'h840, 12'h880, 12'h8C0, 12'h900, 12'h980, 12'hA00};
`ifdef INTERP_ROUND_EN
    logic [11:0] exp_rnd   [5] = '{12'h800, 12'h800, 12'h801, 12'h801, 12'h802};
`else
    logic [11:0] exp_rnd   [5] = '{12'h800, 12'h800, 12'h800, 12'h801, 12'h801};
`endif

    task automatic cycle();
        @(posedge Fg_CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.tick      = 1'b0;
        cycle();
        RESET = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        cycle();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_data !== OUT_RESET_CODE) begin errors++; $display("FAIL reset_out_data: got %h want %h", bus.out_data, OUT_RESET_CODE); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
        RESET = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL empty_in_ready: got %b want 1", bus.in_ready); end
        pulse_tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.underrun !== 1'b0) begin errors++; $display("FAIL empty_tick: got valid=%b underrun=%b want 0 0", bus.out_valid, bus.underrun); end
    endtask

    task automatic test_ramp();
        do_reset();
        bus.ratio_sel = 4'd2;
        push(16'd0);
        push(16'd4096);
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_ramp[i] || bus.underrun !== 1'b0) begin errors++; $display("FAIL ramp_%0d: got v=%b d=%h u=%b want 1 %h 0", i, bus.out_valid, bus.out_data, bus.underrun, exp_ramp[i]); end
        end
        cycle();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 12'h8C0) begin errors++; $display("FAIL ramp_hold: got v=%b d=%h want 0 8c0", bus.out_valid, bus.out_data); end
        pulse_tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 12'h900 || bus.underrun !== 1'b1) begin errors++; $display("FAIL ramp_underrun: got v=%b d=%h u=%b want 1 900 1", bus.out_valid, bus.out_data, bus.underrun); end
    endtask

    task automatic test_passthrough();
        do_reset();
        bus.ratio_sel = 4'd0;
        push(pt_stream[0]);
        push(pt_stream[1]);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pt_stream[i+2];
            bus.tick     = 1'b1;
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL pt_ready_%0d: got %b want 1", i, bus.in_ready); end
            cycle();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_pt[i] || bus.underrun !== 1'b0) begin errors++; $display("FAIL pt_out_%0d: got v=%b d=%h u=%b want 1 %h 0", i, bus.out_valid, bus.out_data, bus.underrun, exp_pt[i]); end
        end
        bus.in_valid = 1'b0;
        bus.tick     = 1'b0;
    endtask

    task automatic test_ratio_change();
        do_reset();
        bus.ratio_sel = 4'd2;
        push(16'd0);
        push(16'd4096);
        push(16'd8192);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rc_stage_full: got %b want 0", bus.in_ready); end
        for (int i = 0; i < 7; i++) begin
            pulse_tick();
            if (i == 0) bus.ratio_sel = 4'd1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_rc[i]) begin errors++; $display("FAIL rc_%0d: got v=%b d=%h want 1 %h", i, bus.out_valid, bus.out_data, exp_rc[i]); end
        end
        checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL rc_underrun: got %b want 1", bus.underrun); end
    endtask

    task automatic test_underrun();
        do_reset();
        bus.ratio_sel = 4'd2;
        push(16'd0);
        push(16'd4096);
        for (int i = 0; i < 4; i++) pulse_tick();
        for (int i = 0; i < 2; i++) begin
            pulse_tick();
            checks++; if (bus.out_data !== 12'h900 || bus.underrun !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ur_pulse_%0d: got d=%h u=%b v=%b want 900 1 1", i, bus.out_data, bus.underrun, bus.out_valid); end
        end
        cycle();
        checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL ur_one_cycle: got %b want 0", bus.underrun); end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd0;
        bus.tick     = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        bus.tick     = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 12'h900) begin errors++; $display("FAIL ur_same_cycle: got v=%b d=%h want 1 900", bus.out_valid, bus.out_data); end
        pulse_tick();
        checks++; if (bus.out_data !== 12'h8C0 || bus.underrun !== 1'b0) begin errors++; $display("FAIL ur_resume: got d=%h u=%b want 8c0 0", bus.out_data, bus.underrun); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ratio_sel = 4'd2;
        push(16'd0);
        push(16'd4096);
        push(16'd8192);
        pulse_tick();
        pulse_tick();
        RESET        = 1'b1;
        bus.tick     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd12288;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready: got %b want 0", bus.in_ready); end
        cycle();
        RESET        = 1'b0;
        bus.tick     = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 12'h800 || bus.underrun !== 1'b0) begin errors++; $display("FAIL rm_outputs: got v=%b d=%h u=%b want 0 800 0", bus.out_valid, bus.out_data, bus.underrun); end
        pulse_tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.underrun !== 1'b0) begin errors++; $display("FAIL rm_tick_empty: got v=%b u=%b want 0 0", bus.out_valid, bus.underrun); end
        push(16'h1000);
        pulse_tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.underrun !== 1'b0) begin errors++; $display("FAIL rm_tick_one: got v=%b u=%b want 0 0", bus.out_valid, bus.underrun); end
        push(16'h2000);
        pulse_tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 12'h900) begin errors++; $display("FAIL rm_restart: got v=%b d=%h want 1 900", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_clamp();
        do_reset();
        bus.ratio_sel = 4'd15;
        push(16'd0);
        push(16'd4096);
        pulse_tick();
        pulse_tick();
        checks++; if (bus.out_data !== 12'h810) begin errors++; $display("FAIL clamp_step: got %h want 810", bus.out_data); end
        for (int i = 0; i < 14; i++) pulse_tick();
        checks++; if (bus.out_data !== 12'h8F0 || bus.underrun !== 1'b0) begin errors++; $display("FAIL clamp_last: got d=%h u=%b want 8f0 0", bus.out_data, bus.underrun); end
        pulse_tick();
        checks++; if (bus.out_data !== 12'h900 || bus.underrun !== 1'b1) begin errors++; $display("FAIL clamp_end: got d=%h u=%b want 900 1", bus.out_data, bus.underrun); end
    endtask

    task automatic test_rounding();
        do_reset();
        bus.ratio_sel = 4'd1;
        push(16'd0);
        push(16'd15);
        push(16'd24);
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            checks++; if (bus.out_data !== exp_rnd[i]) begin errors++; $display("FAIL rnd_%0d: got %h want %h", i, bus.out_data, exp_rnd[i]); end
        end
        do_reset();
        bus.ratio_sel = 4'd0;
        push(16'd32767);
        push(16'd32767);
        pulse_tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 12'hFFF) begin errors++; $display("FAIL rnd_max: got v=%b d=%h want 1 fff", bus.out_valid, bus.out_data); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
        bus.ratio_sel = 4'd0;
        bus.tick      = 1'b0;
        test_reset();
        test_ramp();
        test_passthrough();
        test_ratio_change();
        test_underrun();
        test_reset_mid();
        test_clamp();
        test_rounding();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/interp_linear_stream.md
Name: interp_linear_stream

Overview:
- Parametrised linear interpolator for the DDS output path. Upsamples a stream of signed waveform samples by R = 2^ratio_sel.
- Produces one interpolated point per tick strobe, as offset-binary DAC code.
- Successor to the fixed-width single-shot interpolator:
  - adds a valid/ready sample input with a one-entry skid stage;
  - power-of-two ratio, so shifts replace dividers;
  - exact per-segment re-anchoring, so there is no accumulator drift;
  - explicit underrun handling.

Parameters:
- DATA_W, 16: signed input sample width.
- OUT_W, 12: output code width (OUT_W <= DATA_W).
- FRAC_W, 16: accumulator fraction bits (FRAC_W >= MAX_LOG2).
- MAX_LOG2, 4: largest ratio_sel honoured (R max = 16).

Ports:
- Fg_CLK  in  1  sole clock
- RESET  in  1  synchronous, active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  DATA_W  signed sample
- ratio_sel  in  4  log2 interpolation ratio; values > MAX_LOG2 clamp to MAX_LOG2
- tick  in  1  output-rate strobe
- out_valid  out  1  one-cycle pulse, new out_data
- out_data  out  OUT_W  offset-binary code (MSB inverted)
- underrun  out  1  one-cycle pulse, tick arrived while starved

Behaviour:
- Interface (already decided): one clock, Fg_CLK; reset RESET is synchronous and active-high.
- Reset:
  - state=EMPTY; cur, nxt, stage, acc, delta, phase = 0.
  - out_valid=0, underrun=0, out_data = {1'b1, zeros} (code for 0).
  - in_ready=0 while RESET high.
- Reset mid-operation discards all samples, including the skid stage, in the cycle it is sampled.
- States:
  - EMPTY: in_ready=1; accept -> cur=in_data -> ONE. tick ignored (no out_valid, no underrun).
  - ONE: in_ready=1; accept -> segment start with (cur, in_data) -> RUN. tick ignored.
  - RUN: in_ready = !stage_full; accept -> stage.
  - HOLD: starved. in_ready=1; acc = nxt<<FRAC_W; delta=0.
- Segment start (cur, nxt):
  - acc = cur<<FRAC_W (exact re-anchor); phase=0.
  - r = clamped ratio_sel, latched here. A ratio change mid-segment applies to the next segment only.
  - delta = sext(nxt - cur, DATA_W+1) <<< (FRAC_W - r).
  - acc width is DATA_W+FRAC_W+1. Intermediate values never exceed the span of cur..nxt.
- On tick in RUN:
  - emit integer part of acc; phase++; acc += delta.
  - If phase == R-1, the segment ends and the next source is chosen in priority order:
    - stage_full: new segment (nxt, stage); stage_full=0.
    - else if an in_data accept happens the same cycle: bypass, new segment (nxt, in_data).
    - else: go to HOLD.
- On tick in HOLD:
  - emit nxt; underrun=1 the following cycle, together with out_valid.
  - accept -> segment (nxt, in_data) -> RUN.
  - An accept and a tick in the same cycle: the tick emits nxt, then the new segment starts.
- Output timing:
  - out_valid and out_data are registered 1 cycle after tick; out_data holds between pulses.
  - Code = top OUT_W bits of integer part acc[DATA_W+FRAC_W-1:FRAC_W], with MSB inverted.
- ratio_sel=0: pass-through, one sample consumed per tick.
- tick asserted on consecutive cycles is legal: one point per cycle.

Optional Feature:
- Macro INTERP_ROUND_EN.
- Defined: before truncation, add 1 << (FRAC_W + DATA_W - OUT_W - 1) to acc; saturate to max positive code on overflow.
- Undefined: plain truncation (floor), no saturation logic.

Decomposition:
- Package interp_pkg holds:
  - state enum (EMPTY, ONE, RUN, HOLD);
  - derived widths ACC_W = DATA_W+FRAC_W+1, DROP_W = FRAC_W+DATA_W-OUT_W;
  - the reset output code constant.
- One sub-module, interp_delta_calc (combinational): subtract, sign-extend, clamp r, shift.
- FSM, skid stage and accumulator live in the top.

Test Plan:
1. DATA_W=16/OUT_W=12, ratio_sel=2. Feed 0 then 4096, then ticks:
   - out_data = 0x800, 0x840, 0x880, 0x8C0;
   - 5th tick with no third sample -> 0x900 plus underrun pulse.
2. ratio_sel=0, samples 0x7FF0, 0x8000, ticks -> 0xFFF then 0x000; no drift; in_ready never stalls the source.
3. Samples 0, 4096, 8192 with ratio_sel changed 2 -> 1 mid-first-segment:
   - first segment stays 4 points;
   - second segment gives 0x900, 0x980, then 0xA00.
4. Starve in RUN, tick twice -> two underrun pulses, out_data=0x900. Then supply 0 plus a same-cycle tick -> 0x900 emitted, next tick 0x8C0.
5. RESET asserted one cycle mid-segment:
   - next cycle out_data=0x800, out_valid=0, state EMPTY, in_ready=0 during reset;
   - ticks ignored until two samples are accepted.
6. INTERP_ROUND_EN: samples 0 -> 15, ratio_sel=1:
   - defined: midpoint 7.5 gives integer 7 then rounds to 0x800;
   - 32767 input -> 0xFFF, with no wrap.
